// File: rtl/acc_mem_responder.sv
// Memory-side responder and run controller for the edge-detection accelerator bus.
// Optional write checksum is built only when ACC_MEM_WR_CHECKSUM_EN is defined.
module acc_mem_responder #(
  parameter int unsigned DEPTH          = 50688,
  parameter int unsigned TIMEOUT_CYCLES = 200000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] addr,
  output logic [31:0] dataR,
  input  logic [31:0] dataW,
  input  logic        en,
  input  logic        we,
  output logic        start,
  input  logic        finish,
  input  logic        go,
  input  logic        host_we,
  input  logic        host_re,
  input  logic [15:0] host_addr,
  input  logic [31:0] host_wdata,
  output logic [31:0] host_rdata,
  output logic        busy,
  output logic        done,
  output logic        timeout,
  output logic        err,
  output logic [15:0] rd_cnt,
  output logic [15:0] wr_cnt,
  output logic [31:0] cyc_cnt,
  output logic [31:0] wr_checksum
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned DW = 32;
  localparam int unsigned CW = 16;

  typedef enum logic [1:0] {S_IDLE, S_START, S_RUN, S_DONE} state_t;

  state_t          r_state;
  logic [DW-1:0]   r_mem [DEPTH];
  logic [DW-1:0]   r_dataR;
  logic [DW-1:0]   r_host_rdata;
  logic            r_start;
  logic            r_busy;
  logic            r_done;
  logic            r_timeout;
  logic            r_err;
  logic [CW-1:0]   r_rd_cnt;
  logic [CW-1:0]   r_wr_cnt;
  logic [DW-1:0]   r_cyc_cnt;

  logic w_run;
  logic w_host_ok;
  logic w_acc_in_range;
  logic w_host_in_range;
  logic w_acc_rd;
  logic w_acc_wr;
  logic w_acc_rd_req;
  logic w_host_wr;
  logic w_host_rd;
  logic w_err_set;
  logic w_go;
  logic w_timeout_hit;

  assign w_run           = (r_state == S_RUN);
  assign w_host_ok       = (r_state == S_IDLE) || (r_state == S_DONE);
  assign w_acc_in_range  = ({1'b0, addr} < 17'(DEPTH));
  assign w_host_in_range = ({1'b0, host_addr} < 17'(DEPTH));
  assign w_acc_rd_req    = w_run && en && !we;
  assign w_acc_rd        = w_acc_rd_req && w_acc_in_range;
  assign w_acc_wr        = w_run && en && we && w_acc_in_range;
  assign w_host_wr       = w_host_ok && host_we && w_host_in_range;
  assign w_host_rd       = w_host_ok && host_re;
  assign w_go            = go && w_host_ok;
  assign w_timeout_hit   = (r_cyc_cnt == DW'(TIMEOUT_CYCLES - 1));

  // Illegal-phase or out-of-range accesses from either side
  assign w_err_set = (en && (!w_run || !w_acc_in_range)) ||
                     ((host_we || host_re) && (!w_host_ok || !w_host_in_range));

  // Phases are exclusive, so the two sides never contend for the single write port
  always_ff @(posedge clk) begin
    if (w_acc_wr) begin
      r_mem[AW'(addr)] <= dataW;
    end else if (w_host_wr) begin
      r_mem[AW'(host_addr)] <= host_wdata;
    end
  end

  // Registered read data; both hold their value when not read
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_dataR      <= '0;
      r_host_rdata <= '0;
    end else begin
      if (w_acc_rd) begin
        r_dataR <= r_mem[AW'(addr)];
      end else if (w_acc_rd_req) begin
        r_dataR <= '0;
      end
      if (w_host_rd) begin
        r_host_rdata <= w_host_in_range ? r_mem[AW'(host_addr)] : '0;
      end
    end
  end

  // Run controller with counters and status flags
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_start   <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_timeout <= 1'b0;
      r_err     <= 1'b0;
      r_rd_cnt  <= '0;
      r_wr_cnt  <= '0;
      r_cyc_cnt <= '0;
    end else begin
      if (w_err_set) begin
        r_err <= 1'b1;
      end else if (w_go) begin
        r_err <= 1'b0;
      end
      case (r_state)
        S_IDLE, S_DONE: begin
          if (w_go) begin
            r_state   <= S_START;
            r_start   <= 1'b1;
            r_busy    <= 1'b1;
            r_done    <= 1'b0;
            r_timeout <= 1'b0;
            r_rd_cnt  <= '0;
            r_wr_cnt  <= '0;
            r_cyc_cnt <= '0;
          end
        end
        S_START: begin
          r_state <= S_RUN;
          r_start <= 1'b0;
        end
        S_RUN: begin
          r_cyc_cnt <= r_cyc_cnt + DW'(1);
          if (w_acc_rd && (r_rd_cnt != '1)) begin
            r_rd_cnt <= r_rd_cnt + CW'(1);
          end
          if (w_acc_wr && (r_wr_cnt != '1)) begin
            r_wr_cnt <= r_wr_cnt + CW'(1);
          end
          if (finish) begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else if (w_timeout_hit) begin
            r_state   <= S_DONE;
            r_busy    <= 1'b0;
            r_done    <= 1'b1;
            r_timeout <= 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_start <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef ACC_MEM_WR_CHECKSUM_EN
  logic [DW-1:0] r_wr_checksum;

  // Wrap-around sum of accepted write payloads mixed with their address
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_checksum <= '0;
    end else if (w_go) begin
      r_wr_checksum <= '0;
    end else if (w_acc_wr) begin
      r_wr_checksum <= r_wr_checksum + (dataW ^ {16'h0, addr});
    end
  end

  assign wr_checksum = r_wr_checksum;
`else
  assign wr_checksum = '0;
`endif

  assign dataR      = r_dataR;
  assign host_rdata = r_host_rdata;
  assign start      = r_start;
  assign busy       = r_busy;
  assign done       = r_done;
  assign timeout    = r_timeout;
  assign err        = r_err;
  assign rd_cnt     = r_rd_cnt;
  assign wr_cnt     = r_wr_cnt;
  assign cyc_cnt    = r_cyc_cnt;

endmodule

// File: tb/tb_acc_mem_responder.sv
// Randomized self-checking bench for acc_mem_responder against a sparse memory model.
module tb_acc_mem_responder;

  localparam int unsigned DEPTH = 50688;
  localparam int unsigned TO    = 100;

  logic        clk;
  logic        reset;
  logic [15:0] addr;
  logic [31:0] dataR;
  logic [31:0] dataW;
  logic        en;
  logic        we;
  logic        start;
  logic        finish;
  logic        go;
  logic        host_we;
  logic        host_re;
  logic [15:0] host_addr;
  logic [31:0] host_wdata;
  logic [31:0] host_rdata;
  logic        busy;
  logic        done;
  logic        timeout;
  logic        err;
  logic [15:0] rd_cnt;
  logic [15:0] wr_cnt;
  logic [31:0] cyc_cnt;
  logic [31:0] wr_checksum;

  acc_mem_responder #(.DEPTH(DEPTH), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .addr(addr), .dataR(dataR), .dataW(dataW),
    .en(en), .we(we), .start(start), .finish(finish), .go(go),
    .host_we(host_we), .host_re(host_re), .host_addr(host_addr),
    .host_wdata(host_wdata), .host_rdata(host_rdata), .busy(busy),
    .done(done), .timeout(timeout), .err(err), .rd_cnt(rd_cnt),
    .wr_cnt(wr_cnt), .cyc_cnt(cyc_cnt), .wr_checksum(wr_checksum)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] mem_m [int];
  int          q_addr [$];
  logic [31:0] exp_dr;
  logic [31:0] exp_ck;
  int          exp_rd;
  int          exp_wr;
  int          run_cyc;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic host_wr(input logic [15:0] a, input logic [31:0] d);
    host_addr = a; host_wdata = d; host_we = 1'b1;
    step();
    host_we = 1'b0;
    if (int'(a) < int'(DEPTH)) begin
      mem_m[int'(a)] = d;
      q_addr.push_back(int'(a));
    end
  endtask

  task automatic host_rd(input logic [15:0] a, input string tag);
    logic [31:0] e;
    host_addr = a; host_re = 1'b1;
    step();
    host_re = 1'b0;
    e = (int'(a) < int'(DEPTH)) ? mem_m[int'(a)] : 32'h0;
    chk(tag, host_rdata, e);
  endtask

  task automatic begin_run();
    go = 1'b1;
    step();
    go = 1'b0;
    chk("start_pulse", 32'(start), 32'h1);
    chk("busy_start", 32'(busy), 32'h1);
    chk("err_cleared", 32'(err), 32'h0);
    chk("timeout_cleared", 32'(timeout), 32'h0);
    step();
    chk("start_one_cycle", 32'(start), 32'h0);
    chk("busy_run", 32'(busy), 32'h1);
    run_cyc = 0; exp_rd = 0; exp_wr = 0; exp_ck = 32'h0;
  endtask

  // One accelerator bus cycle in RUN, updating the model by the access rules
  task automatic acc_op(input logic e, input logic w, input logic [15:0] a, input logic [31:0] d);
    en = e; we = w; addr = a; dataW = d;
    step();
    en = 1'b0; we = 1'b0;
    run_cyc++;
    if (e && int'(a) < int'(DEPTH)) begin
      if (w) begin
        mem_m[int'(a)] = d;
        q_addr.push_back(int'(a));
        exp_wr++;
`ifdef ACC_MEM_WR_CHECKSUM_EN
        exp_ck = exp_ck + (d ^ {16'h0, a});
`endif
      end else begin
        exp_dr = mem_m[int'(a)];
        exp_rd++;
      end
    end else if (e && !w) begin
      exp_dr = 32'h0;
    end
    chk("dataR", dataR, exp_dr);
  endtask

  task automatic end_run(input bit chk_rd);
    finish = 1'b1;
    step();
    finish = 1'b0;
    run_cyc++;
    chk("done", 32'(done), 32'h1);
    chk("busy_done", 32'(busy), 32'h0);
    chk("timeout_fin", 32'(timeout), 32'h0);
    chk("cyc_cnt", cyc_cnt, 32'(run_cyc));
    chk("wr_cnt", 32'(wr_cnt), 32'(exp_wr));
    if (chk_rd) chk("rd_cnt", 32'(rd_cnt), 32'(exp_rd));
    chk("wr_checksum", wr_checksum, exp_ck);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, cnt, idx;
    logic [15:0] a;
    logic [31:0] d;
    reset = 1'b0; addr = '0; dataW = '0; en = 1'b0; we = 1'b0; finish = 1'b0;
    go = 1'b0; host_we = 1'b0; host_re = 1'b0; host_addr = '0; host_wdata = '0;
    exp_dr = 32'h0; exp_ck = 32'h0;
    #23;
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_start", 32'(start), 32'h0);
    chk("rst_err", 32'(err), 32'h0);
    chk("rst_dataR", dataR, 32'h0);
    chk("rst_host_rdata", host_rdata, 32'h0);
    chk("rst_cyc", cyc_cnt, 32'h0);
    chk("rst_cksum", wr_checksum, 32'h0);
    @(negedge clk);
    reset = 1'b1;

    // Host load and readback
    host_wr(16'd5, 32'hA1B2C3D4);
    host_rd(16'd5, "host_rd5");
    host_wr(16'd6, 32'h0BADF00D);
    for (int i = 0; i < 8; i++) host_wr(16'($urandom_range(8, 1023)), $urandom);
    for (int i = 0; i < 4; i++) host_rd(16'(q_addr[$urandom_range(0, q_addr.size() - 1)]), "host_rd_rand");

    // Directed run: read, then 88 result writes leaving dataR untouched
    begin_run();
    acc_op(1'b1, 1'b0, 16'd5, 32'h0);
    chk("dataR_rd5", dataR, 32'hA1B2C3D4);
    for (int i = 0; i < 88; i++) acc_op(1'b1, 1'b1, 16'(25344 + i), 32'h0);
    chk("dataR_hold_wr", dataR, 32'hA1B2C3D4);
    end_run(1'b1);
    chk("wr_cnt_88", 32'(wr_cnt), 32'd88);

    // Randomized runs
    for (int r = 0; r < 4; r++) begin
      begin_run();
      n = $urandom_range(20, 60);
      for (int k = 0; k < n; k++) begin
        case ($urandom_range(0, 2))
          0: acc_op(1'b1, 1'b0, 16'(q_addr[$urandom_range(0, q_addr.size() - 1)]), $urandom);
          1: begin
            a = $urandom_range(0, 1) ? 16'($urandom_range(7, 1023)) : 16'($urandom_range(25344, 26367));
            acc_op(1'b1, 1'b1, a, $urandom);
          end
          default: acc_op(1'b0, 1'($urandom_range(0, 1)), 16'($urandom), $urandom);
        endcase
      end
      end_run(1'b1);
      for (int i = 0; i < 4; i++) host_rd(16'(q_addr[$urandom_range(0, q_addr.size() - 1)]), "readback");
    end

    // Checksum example
    begin_run();
    acc_op(1'b1, 1'b1, 16'd1, 32'h10);
    acc_op(1'b1, 1'b1, 16'd2, 32'h20);
    end_run(1'b1);
`ifdef ACC_MEM_WR_CHECKSUM_EN
    chk("cksum_33", wr_checksum, 32'h33);
`else
    chk("cksum_off", wr_checksum, 32'h0);
`endif

    // Errors inside RUN: out-of-range read, host write, ignored go
    begin_run();
    acc_op(1'b1, 1'b0, 16'd5, 32'h0);
    acc_op(1'b1, 1'b0, 16'hFFFF, 32'h0);
    chk("oor_dataR", dataR, 32'h0);
    chk("oor_err", 32'(err), 32'h1);
    host_addr = 16'd5; host_wdata = 32'hDEADBEEF; host_we = 1'b1;
    step();
    host_we = 1'b0; run_cyc++;
    go = 1'b1;
    step();
    go = 1'b0; run_cyc++;
    chk("go_in_run", 32'(start), 32'h0);
    end_run(1'b0);
    chk("err_sticky", 32'(err), 32'h1);
    host_rd(16'd5, "host_wr_ignored");

    // Accelerator access outside RUN is ignored and flags err
    begin_run();
    end_run(1'b1);
    chk("err_clean", 32'(err), 32'h0);
    en = 1'b1; we = 1'b1; addr = 16'd6; dataW = 32'h12345678;
    step();
    en = 1'b0; we = 1'b0;
    chk("err_idle_acc", 32'(err), 32'h1);
    host_rd(16'd6, "acc_wr_ignored");
    host_rd(16'hFFFF, "host_oor_rd");

    // Simultaneous host write and read returns the old word
    d = $urandom;
    host_addr = 16'd5; host_wdata = d; host_we = 1'b1; host_re = 1'b1;
    step();
    host_we = 1'b0; host_re = 1'b0;
    chk("rbw_old", host_rdata, mem_m[5]);
    mem_m[5] = d;
    host_rd(16'd5, "rbw_new");

    // Timeout with no finish
    begin_run();
    cnt = 0;
    while (!done && cnt < 300) begin
      step();
      cnt++;
    end
    chk("to_cycles", 32'(cnt), 32'(TO));
    chk("to_flag", 32'(timeout), 32'h1);
    chk("to_cyc_cnt", cyc_cnt, 32'(TO));
    chk("to_busy", 32'(busy), 32'h0);

    // finish on the timeout cycle wins
    begin_run();
    for (int i = 0; i < int'(TO) - 1; i++) step();
    finish = 1'b1;
    step();
    finish = 1'b0;
    chk("fin_vs_to_done", 32'(done), 32'h1);
    chk("fin_vs_to_flag", 32'(timeout), 32'h0);
    chk("fin_vs_to_cyc", cyc_cnt, 32'(TO));

    // Asynchronous reset mid-run
    begin_run();
    idx = $urandom_range(2, 10);
    for (int i = 0; i < idx; i++) step();
    #2;
    reset = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(busy), 32'h0);
    chk("mid_rst_cyc", cyc_cnt, 32'h0);
    chk("mid_rst_done", 32'(done), 32'h0);
    @(negedge clk);
    reset = 1'b1;
    step();
    chk("post_rst_idle", 32'(busy), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
